// File: rtl/am2910_intctl_pkg.sv
// Shared types, default parameters and the vector address helper for the am2910 interrupt controller.
package am2910_intctl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } state_t;

    localparam int unsigned DEF_NREQ   = 8;
    localparam int unsigned DEF_WIDTH  = 12;
    localparam int unsigned DEF_VBASE  = 32'h200;
    localparam int unsigned DEF_VSHIFT = 2;

    // Handler slot address; caller truncates to the D-bus width.
    function automatic int unsigned vector_addr(input int unsigned base,
                                                input int unsigned lvl,
                                                input int unsigned shift);
        return base + (lvl << shift);
    endfunction

endpackage

// File: rtl/am2910_intctl_defs.vh
// Command codes shared by the interrupt controller and anything that issues commands to it.
`ifndef AM2910_INTCTL_DEFS_VH
`define AM2910_INTCTL_DEFS_VH
`define INTCTL_CMD_NOP      3'b000
`define INTCTL_CMD_LDMASK   3'b001
`define INTCTL_CMD_SETMASK  3'b010
`define INTCTL_CMD_CLRMASK  3'b011
`define INTCTL_CMD_CLRPEND  3'b100
`define INTCTL_CMD_EOI      3'b101
`define INTCTL_CMD_ENABLE   3'b110
`define INTCTL_CMD_DISABLE  3'b111
`endif

// File: rtl/am29xx_prienc.sv
// Lowest-set-index priority encoder; bit 0 has the highest priority.
module am29xx_prienc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  in_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o   = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/am2910_intctl.sv
// Priority interrupt/vector controller feeding int_ to the am2910 CC mux and a handler
// vector onto the shared D bus while the sequencer holds vect_ low.
`include "am2910_intctl_defs.vh"

module am2910_intctl
    import am2910_intctl_pkg::*;
#(
    parameter int          NREQ   = DEF_NREQ,
    parameter int          WIDTH  = DEF_WIDTH,
    parameter int unsigned VBASE  = DEF_VBASE,
    parameter int unsigned VSHIFT = DEF_VSHIFT,
    parameter int          LW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             cp,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             cmd_en,
    input  logic [2:0]       cmd,
    input  logic [NREQ-1:0]  cmd_d,
    input  logic             vect_,
    output logic             int_,
    output logic [WIDTH-1:0] vec,
    output logic [NREQ-1:0]  pend,
    output logic [NREQ-1:0]  mask,
    output logic [NREQ-1:0]  isr,
    output logic             gie
);

    state_t          state_q, state_d;
    logic [LW-1:0]   vsel_q, vsel_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic [NREQ-1:0] isr_q, isr_d;
    logic            gie_q, gie_d;

    logic [NREQ-1:0] elig_bits;
    logic [LW-1:0]   top_idx, isr_idx;
    logic            top_valid, isr_valid;
    logic            eligible, ack, eoi_cmd;
    logic [NREQ-1:0] ack_bit, eoi_bit;
    logic [WIDTH-1:0] vec_val;

    assign elig_bits = pend_q & ~mask_q;

    am29xx_prienc #(.N(NREQ), .IW(LW)) u_enc_elig (
        .in_i    (elig_bits),
        .idx_o   (top_idx),
        .valid_o (top_valid)
    );

    am29xx_prienc #(.N(NREQ), .IW(LW)) u_enc_isr (
        .in_i    (isr_q),
        .idx_o   (isr_idx),
        .valid_o (isr_valid)
    );

    // Only a strictly higher priority than the innermost in-service level may nest.
    assign eligible = gie_q && top_valid && (!isr_valid || (top_idx < isr_idx));
    assign ack      = (state_q == ST_ASSERT) && !vect_;
    assign eoi_cmd  = cmd_en && (cmd == `INTCTL_CMD_EOI);

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_bits
            assign ack_bit[gi] = ack && (vsel_q == LW'(gi));
            assign eoi_bit[gi] = eoi_cmd && isr_valid && (isr_idx == LW'(gi));
        end
    endgenerate

    always_comb begin
        pend_d = pend_q | req;
        mask_d = mask_q;
        gie_d  = gie_q;
        if (cmd_en) begin
            case (cmd)
                `INTCTL_CMD_LDMASK:  mask_d = cmd_d;
                `INTCTL_CMD_SETMASK: mask_d = mask_q | cmd_d;
                `INTCTL_CMD_CLRMASK: mask_d = mask_q & ~cmd_d;
                `INTCTL_CMD_CLRPEND: pend_d = pend_d & ~cmd_d;
                `INTCTL_CMD_ENABLE:  gie_d  = 1'b1;
                `INTCTL_CMD_DISABLE: gie_d  = 1'b0;
                default: ;
            endcase
        end
        // Acknowledge is never blocked by same-edge commands or request sets.
        pend_d = pend_d & ~ack_bit;
        isr_d  = (isr_q & ~eoi_bit) | ack_bit;
    end

    always_comb begin
        state_d = state_q;
        vsel_d  = vsel_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d = ST_ASSERT;
                    vsel_d  = top_idx;
                end
            end
            ST_ASSERT: begin
                if (!vect_) begin
                    state_d = ST_IDLE;
                end else if (eligible) begin
                    vsel_d = top_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vsel_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
            isr_q   <= '0;
            gie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsel_q  <= vsel_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            isr_q   <= isr_d;
            gie_q   <= gie_d;
        end
    end

    assign vec_val = WIDTH'(vector_addr(VBASE, 32'(vsel_q), VSHIFT));
    assign vec     = vect_ ? {WIDTH{1'bz}} : vec_val;

    assign int_ = (state_q != ST_ASSERT);
    assign pend = pend_q;
    assign mask = mask_q;
    assign isr  = isr_q;
    assign gie  = gie_q;

endmodule

// File: tb/tb_am2910_intctl.sv
// Directed and random checks of am2910_intctl against a behavioural model of the controller rules.
module tb_am2910_intctl;

    logic       cp = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       cmd_en = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic [7:0] cmd_d = 8'h00;
    logic       vect_ = 1'b1;
    wire        int_;
    wire [11:0] vec;
    wire [7:0]  pend, mask, isr;
    wire        gie;

    always #5 cp = ~cp;

    am2910_intctl #(.NREQ(8), .WIDTH(12), .VBASE(32'h200), .VSHIFT(2)) dut (
        .cp(cp), .rst(rst), .req(req), .cmd_en(cmd_en), .cmd(cmd), .cmd_d(cmd_d),
        .vect_(vect_), .int_(int_), .vec(vec), .pend(pend), .mask(mask),
        .isr(isr), .gie(gie)
    );

    // Model state: asserting = int_ low; vsel = level whose vector is presented.
    bit [7:0] m_pend, m_mask, m_isr;
    bit       m_gie, m_asrt;
    int       m_vsel;
    int       n_checks = 0;
    int       n_pass = 0;

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'hFF; m_isr = 8'h00;
        m_gie = 1'b0; m_asrt = 1'b0; m_vsel = 0;
    endtask

    task automatic model_edge();
        bit [7:0] np, nm, ni;
        bit       ng, na, elig, ack;
        int       nv, top, itop;
        top  = lowest(m_pend & ~m_mask);
        itop = lowest(m_isr);
        elig = m_gie && (top < 8) && (top < itop);
        ack  = m_asrt && !vect_;
        np = m_pend | req; nm = m_mask; ni = m_isr; ng = m_gie; na = m_asrt; nv = m_vsel;
        if (cmd_en) begin
            case (cmd)
                3'd1: nm = cmd_d;
                3'd2: nm = m_mask | cmd_d;
                3'd3: nm = m_mask & ~cmd_d;
                3'd4: np = np & ~cmd_d;
                3'd5: if (itop < 8) ni[itop] = 1'b0;
                3'd6: ng = 1'b1;
                3'd7: ng = 1'b0;
                default: ;
            endcase
        end
        if (ack) begin
            np[m_vsel] = 1'b0;
            ni[m_vsel] = 1'b1;
            na = 1'b0;
        end else if (elig) begin
            na = 1'b1;
            nv = top;
        end else begin
            na = 1'b0;
        end
        m_pend = np; m_mask = nm; m_isr = ni; m_gie = ng; m_asrt = na; m_vsel = nv;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all();
        chk("int_", 32'(int_), 32'(!m_asrt));
        chk("pend", 32'(pend), 32'(m_pend));
        chk("mask", 32'(mask), 32'(m_mask));
        chk("isr",  32'(isr),  32'(m_isr));
        chk("gie",  32'(gie),  32'(m_gie));
        if (!vect_) chk("vec", 32'(vec), 32'h200 + 32'(m_vsel * 4));
    endtask

    task automatic drv(input bit [7:0] r, input bit ce, input bit [2:0] c,
                       input bit [7:0] d, input bit v);
        req = r; cmd_en = ce; cmd = c; cmd_d = d; vect_ = v;
    endtask

    task automatic step();
        model_edge();
        @(posedge cp);
        #1;
        check_all();
    endtask

    task automatic idle();
        drv(8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
    endtask

    task automatic do_cmd(input bit [2:0] c, input bit [7:0] d);
        drv(8'h00, 1'b1, c, d, 1'b1);
        step();
        idle();
    endtask

    initial begin
        // 1. reset state, then requests with gie=0
        model_reset();
        repeat (2) @(posedge cp);
        #1;
        rst = 1'b0;
        check_all();
        chk("rst_mask", 32'(mask), 32'h0FF);
        chk("rst_int", 32'(int_), 32'h1);
        drv(8'hFF, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle();
        chk("t1_pend", 32'(pend), 32'h0FF);
        step();
        chk("t1_int", 32'(int_), 32'h1);

        // 2. basic vectoring
        do_cmd(3'd1, 8'h00);
        do_cmd(3'd4, 8'hFF);
        do_cmd(3'd6, 8'h00);
        drv(8'h02, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        chk("t2_int", 32'(int_), 32'h0);
        vect_ = 1'b0; #1;
        chk("t2_vec", 32'(vec), 32'h204);
        step(); idle();
        chk("t2_isr", 32'(isr), 32'h02);
        chk("t2_pend", 32'(pend), 32'h00);

        // 3. nesting and EOI
        drv(8'h08, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        chk("t3_nonest", 32'(int_), 32'h1);
        drv(8'h01, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        chk("t3_int", 32'(int_), 32'h0);
        vect_ = 1'b0; #1;
        chk("t3_vec0", 32'(vec), 32'h200);
        step(); idle();
        chk("t3_isr", 32'(isr), 32'h03);
        do_cmd(3'd5, 8'h00);
        chk("t3_eoi1", 32'(isr), 32'h02);
        do_cmd(3'd5, 8'h00);
        chk("t3_eoi2", 32'(isr), 32'h00);
        step();
        vect_ = 1'b0; #1;
        chk("t3_vec3", 32'(vec), 32'h20C);
        step(); idle();
        do_cmd(3'd5, 8'h00);

        // 4. masking
        do_cmd(3'd1, 8'h01);
        drv(8'h05, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        vect_ = 1'b0; #1;
        chk("t4_vec", 32'(vec), 32'h208);
        step(); idle();
        chk("t4_pend", 32'(pend), 32'h01);
        chk("t4_isr", 32'(isr), 32'h04);

        // 5. preemption and same-edge races
        do_cmd(3'd5, 8'h00);
        do_cmd(3'd4, 8'h01);
        do_cmd(3'd1, 8'h00);
        drv(8'h04, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        drv(8'h01, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        vect_ = 1'b0; #1;
        chk("t5_preempt", 32'(vec), 32'h200);
        step(); idle();
        do_cmd(3'd5, 8'h00);
        step();
        drv(8'h00, 1'b0, 3'd0, 8'h00, 1'b0); step(); idle();
        chk("t5_isr4", 32'(isr), 32'h04);
        drv(8'h01, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        drv(8'h00, 1'b1, 3'd5, 8'h00, 1'b0); step(); idle();
        chk("t5_ack_eoi", 32'(isr), 32'h01);
        do_cmd(3'd5, 8'h00);
        drv(8'h02, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        drv(8'h00, 1'b1, 3'd7, 8'h00, 1'b0); step(); idle();
        chk("t5_ack_dis_isr", 32'(isr), 32'h02);
        chk("t5_ack_dis_gie", 32'(gie), 32'h0);

        // 6. asynchronous reset while vectoring
        do_cmd(3'd6, 8'h00);
        do_cmd(3'd5, 8'h00);
        drv(8'h08, 1'b0, 3'd0, 8'h00, 1'b1); step(); idle(); step();
        vect_ = 1'b0; #1;
        chk("t6_vec_pre", 32'(vec), 32'h20C);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_int", 32'(int_), 32'h1);
        chk("t6_isr", 32'(isr), 32'h00);
        chk("t6_vec", 32'(vec), 32'h200);
        @(posedge cp); #1;
        rst = 1'b0;
        idle();
        check_all();

        // Random phase
        for (int k = 0; k < 500; k++) begin
            bit [7:0] r;
            bit       ce;
            bit [2:0] c;
            r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ce = ($urandom_range(0, 2) == 0);
            c  = 3'($urandom);
            if (c == 3'd7 && $urandom_range(0, 1) == 0) c = 3'd6;
            drv(r, ce, c, 8'($urandom), ($urandom_range(0, 2) != 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
